// File: rtl/draw_scheduler_if.sv
// Processor plot, obstacle-memory read and VGA plot bus around draw_scheduler.
// The master modport is the scheduler's view of the bus; slave is the surroundings.
interface draw_scheduler_if;
    logic [7:0] proc_x;
    logic [7:0] proc_y;
    logic [2:0] proc_color;
    logic       proc_plot;
    logic [7:0] obs_x;
    logic [7:0] obs_y;
    logic [2:0] obs_mem;
    logic [7:0] vga_x;
    logic [7:0] vga_y;
    logic [2:0] vga_color;
    logic       vga_plot;

    modport master (
        input  proc_x, proc_y, proc_color, proc_plot, obs_mem,
        output obs_x, obs_y, vga_x, vga_y, vga_color, vga_plot
    );

    modport slave (
        output proc_x, proc_y, proc_color, proc_plot, obs_mem,
        input  obs_x, obs_y, vga_x, vga_y, vga_color, vga_plot
    );
endinterface

// File: rtl/draw_scheduler.sv
// Full-screen redraw sequencer (optional background clear, obstacle cell scan) with a
// processor plot FIFO drained while idle. Define DRAW_CLEAR_EN to build the clear sweep.
module draw_scheduler #(
    parameter int unsigned SCR_W    = 160,
    parameter int unsigned SCR_H    = 120,
    parameter int unsigned CELL     = 8,
    parameter logic [2:0]  BG_COLOR = 3'b000,
    parameter int unsigned PQ_DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_redraw,
    draw_scheduler_if.master bus,
    output logic             busy,
    output logic             done,
    output logic             ovf
);
    localparam logic [7:0]  LAST_CX = 8'(SCR_W / CELL - 1);
    localparam logic [7:0]  LAST_CY = 8'(SCR_H / CELL - 1);
    localparam logic [7:0]  LAST_D  = 8'(CELL - 1);
    localparam int unsigned PQ_AW   = $clog2(PQ_DEPTH);

`ifdef DRAW_CLEAR_EN
    localparam logic [7:0] LAST_PX = 8'(SCR_W - 1);
    localparam logic [7:0] LAST_PY = 8'(SCR_H - 1);
    typedef enum logic [2:0] {IDLE, CLEAR, OBS_ADDR, OBS_WAIT, OBS_DRAW} state_t;
    localparam state_t FIRST_STATE = CLEAR;
`else
    typedef enum logic [2:0] {IDLE, OBS_ADDR, OBS_WAIT, OBS_DRAW} state_t;
    localparam state_t FIRST_STATE = OBS_ADDR;
`endif

    state_t state, state_nx;

`ifdef DRAW_CLEAR_EN
    logic [7:0] px, py, px_nx, py_nx;
`endif
    logic [7:0] cx, cy, dx, dy;
    logic [7:0] cx_nx, cy_nx, dx_nx, dy_nx;
    logic [2:0] cell_color, cell_color_nx;
    logic       pending, pending_nx;
    logic       done_nx;
    logic       advance, last_cell;

    logic [7:0] obs_x_q, obs_y_q;
    logic [7:0] pix_x, pix_y;
    logic [2:0] pix_color;
    logic       pix_plot;
    logic [7:0] vga_x_q, vga_y_q;
    logic [2:0] vga_color_q;
    logic       vga_plot_q;

    logic [18:0]      fifo_mem [PQ_DEPTH];
    logic [PQ_AW-1:0] wr_ptr, rd_ptr;
    logic [PQ_AW:0]   count;
    logic             fifo_full, push, pop;

    assign fifo_full = (count == (PQ_AW + 1)'(PQ_DEPTH));
    // A full FIFO still accepts a write when the same cycle pops an entry.
    assign push      = bus.proc_plot && (!fifo_full || pop);
    assign last_cell = (cx == LAST_CX) && (cy == LAST_CY);

    assign busy          = (state != IDLE);
    assign bus.obs_x     = (state == OBS_ADDR) ? cx : obs_x_q;
    assign bus.obs_y     = (state == OBS_ADDR) ? cy : obs_y_q;
    assign bus.vga_x     = vga_x_q;
    assign bus.vga_y     = vga_y_q;
    assign bus.vga_color = vga_color_q;
    assign bus.vga_plot  = vga_plot_q;

    always_comb begin
        state_nx      = state;
`ifdef DRAW_CLEAR_EN
        px_nx         = px;
        py_nx         = py;
`endif
        cx_nx         = cx;
        cy_nx         = cy;
        dx_nx         = dx;
        dy_nx         = dy;
        cell_color_nx = cell_color;
        pending_nx    = pending | (start_redraw & busy);
        done_nx       = 1'b0;
        advance       = 1'b0;
        pop           = 1'b0;
        pix_x         = '0;
        pix_y         = '0;
        pix_color     = '0;
        pix_plot      = 1'b0;

        case (state)
            IDLE: begin
                if (start_redraw || pending) begin
                    pending_nx = 1'b0;
                    state_nx   = FIRST_STATE;
`ifdef DRAW_CLEAR_EN
                    px_nx      = '0;
                    py_nx      = '0;
`endif
                    cx_nx      = '0;
                    cy_nx      = '0;
                end else if (count != '0) begin
                    pop                        = 1'b1;
                    pix_plot                   = 1'b1;
                    {pix_x, pix_y, pix_color}  = fifo_mem[rd_ptr];
                end
            end
`ifdef DRAW_CLEAR_EN
            CLEAR: begin
                pix_plot  = 1'b1;
                pix_x     = px;
                pix_y     = py;
                pix_color = BG_COLOR;
                if (px == LAST_PX) begin
                    px_nx = '0;
                    if (py == LAST_PY) begin
                        state_nx = OBS_ADDR;
                        cx_nx    = '0;
                        cy_nx    = '0;
                    end else begin
                        py_nx = py + 8'd1;
                    end
                end else begin
                    px_nx = px + 8'd1;
                end
            end
`endif
            OBS_ADDR: state_nx = OBS_WAIT;
            OBS_WAIT: begin
                dx_nx = '0;
                dy_nx = '0;
`ifdef DRAW_CLEAR_EN
                cell_color_nx = bus.obs_mem;
                if (bus.obs_mem != 3'b000) state_nx = OBS_DRAW;
                else                       advance  = 1'b1;
`else
                // Without the clear sweep, empty cells are painted as background squares.
                cell_color_nx = (bus.obs_mem == 3'b000) ? BG_COLOR : bus.obs_mem;
                state_nx      = OBS_DRAW;
`endif
            end
            OBS_DRAW: begin
                pix_plot  = 1'b1;
                pix_x     = 8'(cx * CELL + dx);
                pix_y     = 8'(cy * CELL + dy);
                pix_color = cell_color;
                if (dx == LAST_D) begin
                    dx_nx = '0;
                    if (dy == LAST_D) advance = 1'b1;
                    else              dy_nx   = dy + 8'd1;
                end else begin
                    dx_nx = dx + 8'd1;
                end
            end
            default: state_nx = IDLE;
        endcase

        if (advance) begin
            if (last_cell) begin
                state_nx = IDLE;
                done_nx  = 1'b1;
                cx_nx    = '0;
                cy_nx    = '0;
            end else begin
                state_nx = OBS_ADDR;
                if (cx == LAST_CX) begin
                    cx_nx = '0;
                    cy_nx = cy + 8'd1;
                end else begin
                    cx_nx = cx + 8'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
`ifdef DRAW_CLEAR_EN
            px          <= '0;
            py          <= '0;
`endif
            cx          <= '0;
            cy          <= '0;
            dx          <= '0;
            dy          <= '0;
            cell_color  <= '0;
            pending     <= 1'b0;
            done        <= 1'b0;
            ovf         <= 1'b0;
            obs_x_q     <= '0;
            obs_y_q     <= '0;
            vga_x_q     <= '0;
            vga_y_q     <= '0;
            vga_color_q <= '0;
            vga_plot_q  <= 1'b0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
        end else begin
            state       <= state_nx;
`ifdef DRAW_CLEAR_EN
            px          <= px_nx;
            py          <= py_nx;
`endif
            cx          <= cx_nx;
            cy          <= cy_nx;
            dx          <= dx_nx;
            dy          <= dy_nx;
            cell_color  <= cell_color_nx;
            pending     <= pending_nx;
            done        <= done_nx;
            vga_x_q     <= pix_x;
            vga_y_q     <= pix_y;
            vga_color_q <= pix_color;
            vga_plot_q  <= pix_plot;
            if (state == OBS_ADDR) begin
                obs_x_q <= cx;
                obs_y_q <= cy;
            end
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
            if (bus.proc_plot && !push) ovf <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= {bus.proc_x, bus.proc_y, bus.proc_color};
    end
endmodule

// File: tb/tb_draw_scheduler.sv
// Randomized self-checking bench for draw_scheduler against a pixel-list reference model
// (16x8 screen, 4-pixel cells, 4-entry plot FIFO); follows the DRAW_CLEAR_EN build setting.
module tb_draw_scheduler;
    localparam int unsigned W     = 16;
    localparam int unsigned H     = 8;
    localparam int unsigned CS    = 4;
    localparam int unsigned NCX   = W / CS;
    localparam int unsigned NCY   = H / CS;
    localparam int unsigned DEPTH = 4;
    localparam logic [2:0]  BG    = 3'b010;
`ifdef DRAW_CLEAR_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 4;
`endif

    logic clk = 1'b0;
    logic reset, start_redraw, busy, done, ovf;
    draw_scheduler_if bus();

    draw_scheduler #(
        .SCR_W(W), .SCR_H(H), .CELL(CS), .BG_COLOR(BG), .PQ_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .reset(reset), .start_redraw(start_redraw),
        .bus(bus), .busy(busy), .done(done), .ovf(ovf)
    );

    always #5 clk = ~clk;

    logic [2:0] map_mem [NCY][NCX];
    always @(posedge clk)
        bus.obs_mem <= (bus.obs_x < NCX && bus.obs_y < NCY) ? map_mem[bus.obs_y[0]][bus.obs_x[1:0]] : 3'b000;

    // Monitor: timestamps every plot and done pulse, counts busy cycles.
    int          cyc = 0;
    int          busy_cnt = 0;
    logic [18:0] seen_pix[$];
    int          seen_ts[$];
    int          done_ts[$];
    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (busy) busy_cnt <= busy_cnt + 1;
        if (bus.vga_plot) begin
            seen_pix.push_back({bus.vga_x, bus.vga_y, bus.vga_color});
            seen_ts.push_back(cyc + 1);
        end
        if (done) done_ts.push_back(cyc + 1);
    end

    int          n_cmp = 0;
    int          n_err = 0;
    logic [18:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int nonempty_cells();
        int n = 0;
        for (int y = 0; y < NCY; y++)
            for (int x = 0; x < NCX; x++)
                if (map_mem[y][x] != 3'b000) n++;
        return n;
    endfunction

    function automatic int redraw_len();
`ifdef DRAW_CLEAR_EN
        return W * H + 2 * NCX * NCY + CS * CS * nonempty_cells();
`else
        return (2 + CS * CS) * NCX * NCY;
`endif
    endfunction

    // Expected pixel list for one redraw of the current map.
    task automatic add_redraw();
        logic [2:0] c;
`ifdef DRAW_CLEAR_EN
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                exp_q.push_back({8'(x), 8'(y), BG});
`endif
        for (int cy = 0; cy < NCY; cy++)
            for (int cx = 0; cx < NCX; cx++) begin
                c = map_mem[cy][cx];
`ifdef DRAW_CLEAR_EN
                if (c == 3'b000) continue;
`endif
                if (c == 3'b000) c = BG;
                for (int dy = 0; dy < CS; dy++)
                    for (int dx = 0; dx < CS; dx++)
                        exp_q.push_back({8'(cx * CS + dx), 8'(cy * CS + dy), c});
            end
    endtask

    task automatic set_map(input int mode);
        for (int y = 0; y < NCY; y++)
            for (int x = 0; x < NCX; x++)
                map_mem[y][x] = (mode == 2 && $urandom_range(0, 1) == 1) ? 3'($urandom_range(1, 7)) : 3'b000;
        if (mode == 1) map_mem[1][2] = 3'b101;
    endtask

    task automatic pulse_start(output int n);
        start_redraw = 1'b1;
        n = cyc + 1;
        tick();
        start_redraw = 1'b0;
    endtask

    task automatic wait_done(input int target, input int budget);
        while (done_ts.size() < target && budget > 0) begin
            tick();
            budget--;
        end
        check("done_count", done_ts.size(), target);
    endtask

    task automatic check_stream(input int base, input string tag);
        check({tag, "_nplots"}, seen_pix.size() - base, exp_q.size());
        for (int i = 0; i < exp_q.size() && base + i < seen_pix.size(); i++)
            check(tag, seen_pix[base + i], exp_q[i]);
    endtask

    function automatic int ts_at(input int idx);
        return (idx < seen_ts.size()) ? seen_ts[idx] : -1;
    endfunction

    task automatic plot(input logic [18:0] p);
        {bus.proc_x, bus.proc_y, bus.proc_color} = p;
        bus.proc_plot = 1'b1;
        tick();
        bus.proc_plot = 1'b0;
    endtask

    initial begin
        int n0, pbase, bbase, dbase, len, k;
        logic [18:0] p;
        logic [18:0] procs[$];

        reset = 1'b1;
        start_redraw = 1'b0;
        bus.proc_x = '0; bus.proc_y = '0; bus.proc_color = '0; bus.proc_plot = 1'b0;
        set_map(0);
        repeat (3) tick();
        reset = 1'b0;
        repeat (10) tick();
        check("rst_vga_x", bus.vga_x, 0);
        check("rst_vga_y", bus.vga_y, 0);
        check("rst_vga_color", bus.vga_color, 0);
        check("rst_vga_plot", bus.vga_plot, 0);
        check("rst_obs_x", bus.obs_x, 0);
        check("rst_obs_y", bus.obs_y, 0);
        check("rst_done", done, 0);
        check("rst_ovf", ovf, 0);
        check("rst_busy", busy, 0);

        // Redraws: empty map, single cell (2,1)=5, then random maps.
        for (int r = 0; r < 5; r++) begin
            set_map(r < 2 ? r : 2);
            exp_q.delete();
            add_redraw();
            len = redraw_len();
            pbase = seen_pix.size(); bbase = busy_cnt; dbase = done_ts.size();
            pulse_start(n0);
            wait_done(dbase + 1, 400);
            repeat (4) tick();
            check_stream(pbase, "redraw_pix");
            check("redraw_busy", busy_cnt - bbase, len);
            check("redraw_done_once", done_ts.size() - dbase, 1);
            check("redraw_latency", ts_at(pbase) - n0, LAT);
        end

        // Idle processor plots, single and back-to-back.
        for (int r = 0; r < 4; r++) begin
            k = $urandom_range(1, 3);
            exp_q.delete();
            pbase = seen_pix.size();
            n0 = cyc + 1;
            for (int j = 0; j < k; j++) begin
                p = 19'($urandom);
                exp_q.push_back(p);
                plot(p);
            end
            repeat (4) tick();
            check_stream(pbase, "idle_plot");
            check("idle_latency", ts_at(pbase) - n0, 2);
        end

        // Six strobes mid-redraw: first DEPTH kept and drawn right after done, rest dropped.
        set_map(2);
        exp_q.delete();
        add_redraw();
        len = exp_q.size();
        pbase = seen_pix.size(); dbase = done_ts.size();
        pulse_start(n0);
        repeat (20) tick();
        check("ovf_before", ovf, 0);
        procs.delete();
        for (int j = 0; j < 6; j++) begin
            p = 19'($urandom);
            procs.push_back(p);
            plot(p);
        end
        for (int j = 0; j < DEPTH; j++) exp_q.push_back(procs[j]);
        wait_done(dbase + 1, 400);
        repeat (8) tick();
        check_stream(pbase, "ovf_pix");
        check("ovf_set", ovf, 1);
        check("fifo_after_done", ts_at(pbase + len) - ((done_ts.size() > dbase) ? done_ts[dbase] : 0), 1);

        // Two requests during a redraw collapse into one follow-on redraw.
        set_map(2);
        exp_q.delete();
        add_redraw();
        add_redraw();
        len = redraw_len();
        pbase = seen_pix.size(); bbase = busy_cnt; dbase = done_ts.size();
        pulse_start(n0);
        repeat (10) tick();
        pulse_start(n0);
        repeat (30) tick();
        pulse_start(n0);
        wait_done(dbase + 2, 800);
        repeat (6) tick();
        check_stream(pbase, "pending_pix");
        check("pending_busy", busy_cnt - bbase, 2 * len);
        check("pending_done_total", done_ts.size() - dbase, 2);
        check("pending_restart", ts_at(pbase + exp_q.size() / 2) -
              ((done_ts.size() > dbase) ? done_ts[dbase] : 0), LAT);
        check("ovf_sticky", ovf, 1);

        // Reset 50 cycles into a redraw with plots queued: no done, nothing drawn afterwards.
        set_map(2);
        dbase = done_ts.size();
        pulse_start(n0);
        repeat (10) tick();
        plot(19'($urandom));
        plot(19'($urandom));
        while (cyc < n0 + 50) tick();
        reset = 1'b1;
        tick();
        check("abort_vga_plot", bus.vga_plot, 0);
        check("abort_busy", busy, 0);
        check("abort_ovf", ovf, 0);
        reset = 1'b0;
        pbase = seen_pix.size();
        repeat (30) tick();
        check("abort_no_plots", seen_pix.size() - pbase, 0);
        check("abort_no_done", done_ts.size() - dbase, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/draw_scheduler.md
# draw_scheduler

Owns the VGA plot port and sequences full-screen redraws: an optional background clear sweep, then a scan of the obstacle memory that paints each non-empty grid cell as a filled square. Per-pixel plots from the processor (player sprite) pass through a small FIFO and are drawn in the idle gaps, so they always land on top of the redrawn scene. Sits between the processor, the obstacle memory read port and the VGA adapter.

## Interface
- SCR_W, 160, screen width in pixels (≤256, multiple of CELL)
- SCR_H, 120, screen height in pixels (≤256, multiple of CELL)
- CELL, 8, obstacle cell edge in pixels (power of two, ≥2)
- BG_COLOR, 3'b000, background color
- PQ_DEPTH, 4, processor plot FIFO depth (power of two, ≥2)

- clk  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- start_redraw  in  1  request one full redraw
- proc_x  in  8  processor pixel x
- proc_y  in  8  processor pixel y
- proc_color  in  3  processor pixel color
- proc_plot  in  1  processor pixel write strobe
- obs_x  out  8  obstacle memory cell column
- obs_y  out  8  obstacle memory cell row
- obs_mem  in  3  cell value; synchronous read, valid 1 cycle after address; 0 = empty
- vga_x, vga_y  out  8  registered pixel coordinates
- vga_color  out  3  registered pixel color
- vga_plot  out  1  registered write strobe
- busy  out  1  state ≠ IDLE
- done  out  1  one-cycle pulse at end of redraw
- ovf  out  1  sticky: processor plot dropped (FIFO full)

## Operation
- Reset: state IDLE, all counters 0, FIFO empty, pending=0; vga_x/vga_y/vga_color/vga_plot/obs_x/obs_y/done/ovf all 0.
- States: IDLE, CLEAR, OBS_ADDR, OBS_WAIT, OBS_DRAW.
- IDLE: if start_redraw or pending → CLEAR (pending cleared). Else if FIFO non-empty, pop one entry and emit it on vga_*.
- CLEAR: row-major sweep py 0..SCR_H-1, px 0..SCR_W-1, one BG_COLOR pixel per cycle; after (SCR_W-1, SCR_H-1) → OBS_ADDR with cx=cy=0.
- OBS_ADDR: obs_x=cx, obs_y=cy → OBS_WAIT.
- OBS_WAIT: sample obs_mem into cell color. If nonzero → OBS_DRAW (dx=dy=0); else advance cell.
- OBS_DRAW: emit (cx*CELL+dx, cy*CELL+dy) with sampled color, dx fastest, CELL² cycles; then advance cell.
- Advance cell: cx+1, wrapping to 0 with cy+1 at SCR_W/CELL; after last cell (SCR_W/CELL-1, SCR_H/CELL-1) → IDLE and pulse done.
- obs_x/obs_y hold their last value outside OBS_ADDR.
- FIFO: enqueue {proc_x, proc_y, proc_color} when proc_plot in any state. Full with simultaneous pop in IDLE: enqueue accepted. Full without pop: entry dropped, ovf set until reset. Pops only in IDLE.
- start_redraw while busy: set pending; the redraw restarts immediately after done. Multiple requests while busy collapse into one.
- Coordinate arithmetic is 8-bit unsigned; parameter limits guarantee no overflow.
- Reset mid-redraw: abort at once to reset state, with no done pulse. Queued plots and pending are discarded.

## Timing
- vga_* registered: a pixel chosen by the FSM in cycle n appears in cycle n+1. vga_plot is low whenever no pixel is emitted.
- Processor plot latency with FIFO empty and IDLE: proc_plot in cycle n, enqueued at edge n, popped in n+1, on vga_* in n+2.
- start_redraw sampled in IDLE at cycle n: CLEAR from n+1, first clear pixel on vga_* at n+2.
- Redraw length = SCR_W·SCR_H (clear) + 2 per cell + CELL² per non-empty cell; busy high exactly that many cycles. done is high in the first IDLE cycle.
- Throughput: one pixel per cycle in CLEAR/OBS_DRAW/IDLE-drain.

## Configuration
- DRAW_CLEAR_EN defined: redraw starts with CLEAR as described.
- Undefined: CLEAR state is not built. The redraw starts at OBS_ADDR, and empty cells (obs_mem=0) are drawn as CELL² BG_COLOR squares, so every pixel is still written exactly once. Redraw length = (2+CELL²) per cell.

## Test plan
(SCR_W=16, SCR_H=8, CELL=4, PQ_DEPTH=4, DRAW_CLEAR_EN defined unless noted.)
- Reset then idle 10 cycles → all outputs 0, busy=0.
- All-zero obstacle map, start_redraw pulse → 128 BG_COLOR plots in row-major order, busy high 144 cycles, done pulses once, 0 obstacle plots.
- Cell (2,1)=3'b101, others 0 → after the clear, 16 plots of color 5 covering x 8..11, y 4..7 (dx fastest); busy high 160 cycles.
- 6 proc_plot strobes on consecutive cycles mid-redraw → first 4 drawn in order right after done, last 2 dropped, ovf=1 until reset.
- start_redraw pulsed twice during a redraw → exactly one further redraw begins the cycle after done; two done pulses total.
- DRAW_CLEAR_EN undefined, all-zero map → 128 BG_COLOR plots in cell order, busy high 144 cycles; reset asserted at cycle 50 → no done pulse, vga_plot=0 the next cycle.
